gpio_reg_ip: RTL and testbench
==============================

GPIO_REG_IP -- requirements
Module: gpio_reg_ip

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, setting the gpio_in synchronizer depth (legal values 2..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port bus_valid, input, 1 bit: a bus access is requested this cycle.
REQ-005 The block SHALL have port bus_we, input, 1 bit: 1 = write, 0 = read; qualified by bus_valid.
REQ-006 The block SHALL have port bus_addr, input, 32 bits: byte address; only bits [11:0] are decoded, bits [31:12] are ignored.
REQ-007 The block SHALL have port bus_wdata, input, 32 bits: write data.
REQ-008 The block SHALL have port bus_rdata, output, 32 bits: registered read data.
REQ-009 The block SHALL have port gpio_in, input, 32 bits: asynchronous pad inputs.
REQ-010 The block SHALL have port gpio_out, output, 32 bits: pad output values.

Function
REQ-011 Register map (offset, access): 0x000 GPIO_DATA RW; 0x004 GPIO_DIR RW (bit = 1 means output); 0x008 GPIO_READ RO; 0x00C GPIO_SET WO; 0x010 GPIO_CLR WO; 0x014 GPIO_TGL WO.
REQ-012 A write SHALL occur on a rising edge where bus_valid = 1 and bus_we = 1, and SHALL take effect that edge.
REQ-013 Write effects: GPIO_DATA <= wdata; GPIO_DIR <= wdata; GPIO_SET: DATA |= wdata; GPIO_CLR: DATA &= ~wdata; GPIO_TGL: DATA ^= wdata.
REQ-014 Writes to GPIO_READ, to unmapped offsets, or to offsets with bus_addr[1:0] != 0 SHALL be ignored.
REQ-015 A read SHALL occur on a rising edge where bus_valid = 1 and bus_we = 0; bus_rdata SHALL be loaded with the selected value at that edge (1-cycle latency).
REQ-016 bus_rdata SHALL hold its last value until the next read, and SHALL NOT change on writes or idle cycles.
REQ-017 Read values: GPIO_DATA returns the DATA register; GPIO_DIR returns the DIR register; GPIO_READ returns (DIR & DATA) | (~DIR & gpio_in_sync).
REQ-018 Reads of GPIO_SET, GPIO_CLR, GPIO_TGL, unmapped offsets, or unaligned addresses SHALL return 0x00000000.
REQ-019 gpio_out SHALL equal DATA & DIR, combinational from the registers; input-direction bits drive 0.
REQ-020 gpio_in SHALL pass through a SYNC_STAGES-flop synchronizer per bit; a stable change becomes visible in GPIO_READ after SYNC_STAGES rising edges.
REQ-021 No wait states: every valid access SHALL complete in one cycle, and there is no ready or error signal.

Reset
REQ-022 While rst_n = 0 the block SHALL asynchronously force DATA = 0, DIR = 0, bus_rdata = 0, and all synchronizer flops = 0, giving gpio_out = 0.
REQ-023 An access coinciding with active reset SHALL be discarded; normal operation begins on the first rising edge after rst_n deasserts.

Structure
REQ-024 A package gpio_reg_pkg SHALL hold the register-offset constants and the 32-bit data-width constant.
REQ-025 The synchronizer SHALL be a sub-module gpio_sync (parameters WIDTH, STAGES), instantiated once; all decode and register logic stays in gpio_reg_ip.

Verification
REQ-026 Reset: with rst_n low, then released, all reads return 0 and gpio_out = 0x00000000.
REQ-027 Write DIR = 0x0000FFFF, then DATA = 0xA5A55A5A, then drive gpio_in = 0xFFFF0000 -> reads: DATA = 0xA5A55A5A, DIR = 0x0000FFFF, READ = 0xFFFF5A5A; gpio_out = 0x00005A5A.
REQ-028 With DATA = 0x000000F0: SET 0x0000000F -> DATA = 0x000000FF; CLR 0x000000F0 -> 0x0000000F; TGL 0xFFFFFFFF -> 0xFFFFFFF0.
REQ-029 Reads of 0x00C, 0x020, and 0x002 -> 0x00000000; writes to 0x008 and 0x002 leave DATA and DIR unchanged.
REQ-030 With DIR = 0, change gpio_in from 0 to 0x12345678 and read GPIO_READ every cycle -> old value 0 until SYNC_STAGES edges have elapsed, then 0x12345678; bus_rdata is unchanged during idle cycles.

Source files
------------

// File: rtl/gpio_reg_pkg.sv
// Shared constants, register select type and offset decoder for the GPIO register block.
package gpio_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 12;

  localparam logic [OFS_W-1:0] OFS_DATA = 12'h000;
  localparam logic [OFS_W-1:0] OFS_DIR  = 12'h004;
  localparam logic [OFS_W-1:0] OFS_READ = 12'h008;
  localparam logic [OFS_W-1:0] OFS_SET  = 12'h00C;
  localparam logic [OFS_W-1:0] OFS_CLR  = 12'h010;
  localparam logic [OFS_W-1:0] OFS_TGL  = 12'h014;

  typedef enum logic [2:0] {
    SEL_DATA,
    SEL_DIR,
    SEL_READ,
    SEL_SET,
    SEL_CLR,
    SEL_TGL,
    SEL_NONE
  } reg_sel_e;

  // Map a decoded offset to a register; unaligned offsets never match and fall to SEL_NONE.
  function automatic reg_sel_e decode_ofs(input logic [OFS_W-1:0] ofs);
    reg_sel_e sel;
    case (ofs)
      OFS_DATA: sel = SEL_DATA;
      OFS_DIR:  sel = SEL_DIR;
      OFS_READ: sel = SEL_READ;
      OFS_SET:  sel = SEL_SET;
      OFS_CLR:  sel = SEL_CLR;
      OFS_TGL:  sel = SEL_TGL;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-bit multi-flop synchronizer for asynchronous pad inputs.
module gpio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the pad value through STAGES flops; all flops clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_reg_ip.sv
// GPIO register block: DATA/DIR registers, set/clear/toggle aliases, synchronized pad readback.
module gpio_reg_ip
  import gpio_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_valid,
  input  logic              bus_we,
  input  logic [31:0]       bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dir_q;
  logic [DATA_W-1:0] gpio_in_sync;
  logic [DATA_W-1:0] rd_mux_c;
  logic              wr_en_c;
  logic              rd_en_c;
  reg_sel_e          sel_c;
  logic              unused_addr_c;

  // Upper address bits are deliberately not decoded.
  assign unused_addr_c = ^bus_addr[31:OFS_W];

  gpio_sync #(
    .WIDTH  (DATA_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .q     (gpio_in_sync)
  );

  assign sel_c   = decode_ofs(bus_addr[OFS_W-1:0]);
  assign wr_en_c = bus_valid & bus_we;
  assign rd_en_c = bus_valid & ~bus_we;

  // Register writes; read-only and unmapped selects are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dir_q  <= '0;
    end else if (wr_en_c) begin
      case (sel_c)
        SEL_DATA: data_q <= bus_wdata;
        SEL_DIR:  dir_q  <= bus_wdata;
        SEL_SET:  data_q <= data_q | bus_wdata;
        SEL_CLR:  data_q <= data_q & ~bus_wdata;
        SEL_TGL:  data_q <= data_q ^ bus_wdata;
        default:  ;
      endcase
    end
  end

  // Read-data selection; write-only and unmapped selects return zero.
  always_comb begin
    rd_mux_c = '0;
    case (sel_c)
      SEL_DATA: rd_mux_c = data_q;
      SEL_DIR:  rd_mux_c = dir_q;
      SEL_READ: rd_mux_c = (dir_q & data_q) | (~dir_q & gpio_in_sync);
      default:  rd_mux_c = '0;
    endcase
  end

  // Read data register; holds its value except on a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= '0;
    end else if (rd_en_c) begin
      bus_rdata <= rd_mux_c;
    end
  end

  assign gpio_out = data_q & dir_q;

endmodule

// File: tb/tb_gpio_reg_ip.sv
// Directed, table-driven bench for gpio_reg_ip.
module tb_gpio_reg_ip;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vec_q[$];

  gpio_reg_ip #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic chk_rd,
                     input logic [31:0] exp_rd, input logic [31:0] exp_out);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_out = exp_out;
    vec_q.push_back(v);
  endtask

  logic [31:0] held;

  initial begin
    // Reset with a write attempted while reset is asserted
    rst_n = 1'b0; bus_valid = 1'b1; bus_we = 1'b1;
    bus_addr = 32'h004; bus_wdata = 32'hFFFF_FFFF; gpio_in = '0;
    idle(3);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_out", gpio_out, 32'h0);
    bus_valid = 1'b0; bus_we = 1'b0;
    rst_n = 1'b1;
    idle(1);
    bus_cycle(1'b0, 32'h000, '0); check("rst_rd_data", bus_rdata, 32'h0);
    bus_cycle(1'b0, 32'h004, '0); check("rst_rd_dir", bus_rdata, 32'h0);
    bus_cycle(1'b0, 32'h008, '0); check("rst_rd_read", bus_rdata, 32'h0);
    check("rst_out_after", gpio_out, 32'h0);

    // Vector table
    add("w_dir",       1, 32'h004, 32'h0000_FFFF, 0, 32'h0,          32'h0000_0000);
    add("w_data",      1, 32'h000, 32'hA5A5_5A5A, 0, 32'h0,          32'h0000_5A5A);
    add("r_data",      0, 32'h000, 32'h0,         1, 32'hA5A5_5A5A,  32'h0000_5A5A);
    add("r_dir",       0, 32'h004, 32'h0,         1, 32'h0000_FFFF,  32'h0000_5A5A);
    add("r_read",      0, 32'h008, 32'h0,         1, 32'hFFFF_5A5A,  32'h0000_5A5A);
    add("w_data_f0",   1, 32'h000, 32'h0000_00F0, 0, 32'h0,          32'h0000_00F0);
    add("w_set",       1, 32'h00C, 32'h0000_000F, 0, 32'h0,          32'h0000_00FF);
    add("r_after_set", 0, 32'h000, 32'h0,         1, 32'h0000_00FF,  32'h0000_00FF);
    add("w_clr",       1, 32'h010, 32'h0000_00F0, 0, 32'h0,          32'h0000_000F);
    add("r_after_clr", 0, 32'h000, 32'h0,         1, 32'h0000_000F,  32'h0000_000F);
    add("w_tgl",       1, 32'h014, 32'hFFFF_FFFF, 0, 32'h0,          32'h0000_FFF0);
    add("r_after_tgl", 0, 32'h000, 32'h0,         1, 32'hFFFF_FFF0,  32'h0000_FFF0);
    add("r_set_reg",   0, 32'h00C, 32'h0,         1, 32'h0,          32'h0000_FFF0);
    add("r_data_2",    0, 32'h000, 32'h0,         1, 32'hFFFF_FFF0,  32'h0000_FFF0);
    add("r_unmapped",  0, 32'h020, 32'h0,         1, 32'h0,          32'h0000_FFF0);
    add("r_data_3",    0, 32'h000, 32'h0,         1, 32'hFFFF_FFF0,  32'h0000_FFF0);
    add("r_unaligned", 0, 32'h002, 32'h0,         1, 32'h0,          32'h0000_FFF0);
    add("r_clr_reg",   0, 32'h010, 32'h0,         1, 32'h0,          32'h0000_FFF0);
    add("w_read_reg",  1, 32'h008, 32'h1234_5678, 0, 32'h0,          32'h0000_FFF0);
    add("w_unaligned", 1, 32'h002, 32'hDEAD_BEEF, 0, 32'h0,          32'h0000_FFF0);
    add("w_dir_unal",  1, 32'h006, 32'h0000_0000, 0, 32'h0,          32'h0000_FFF0);
    add("w_unmapped",  1, 32'h018, 32'h0000_0000, 0, 32'h0,          32'h0000_FFF0);
    add("r_data_keep", 0, 32'h000, 32'h0,         1, 32'hFFFF_FFF0,  32'h0000_FFF0);
    add("r_dir_keep",  0, 32'h004, 32'h0,         1, 32'h0000_FFFF,  32'h0000_FFF0);
    add("w_alias_hi",  1, 32'hFFFF_F000, 32'h0000_1234, 0, 32'h0,    32'h0000_1234);
    add("r_alias_hi",  0, 32'h1234_5000, 32'h0,   1, 32'h0000_1234,  32'h0000_1234);
    add("r_read_mix",  0, 32'h008, 32'h0,         1, 32'hFFFF_1234,  32'h0000_1234);

    gpio_in = 32'hFFFF_0000;
    idle(SYNC + 2);
    foreach (vec_q[i]) begin
      bus_cycle(vec_q[i].we, vec_q[i].addr, vec_q[i].wdata);
      if (vec_q[i].chk_rd) check({vec_q[i].name, "_rdata"}, bus_rdata, vec_q[i].exp_rd);
      check({vec_q[i].name, "_out"}, gpio_out, vec_q[i].exp_out);
    end

    // rdata holds across writes and idle cycles
    held = bus_rdata;
    bus_cycle(1'b1, 32'h000, 32'h5555_0000);
    check("hold_on_write", bus_rdata, held);
    idle(2);
    check("hold_on_idle", bus_rdata, held);

    // Synchronizer latency with DIR = 0 and continuous reads of GPIO_READ
    bus_cycle(1'b1, 32'h004, 32'h0);
    gpio_in = 32'h0;
    idle(SYNC + 2);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 32'h008;
    idle(1);
    check("sync_base", bus_rdata, 32'h0);
    gpio_in = 32'h1234_5678;
    for (int k = 1; k <= int'(SYNC) + 2; k++) begin
      idle(1);
      check($sformatf("sync_edge%0d", k), bus_rdata,
            (k > int'(SYNC)) ? 32'h1234_5678 : 32'h0);
    end
    bus_valid = 1'b0;
    gpio_in = 32'h0;
    idle(SYNC + 2);
    check("sync_hold_idle", bus_rdata, 32'h1234_5678);

    // Asynchronous reset mid-operation, with an access during reset
    bus_cycle(1'b1, 32'h004, 32'hFFFF_FFFF);
    check("pre_rst_out", gpio_out, 32'h5555_0000);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", gpio_out, 32'h0);
    check("async_rst_rdata", bus_rdata, 32'h0);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 32'h000; bus_wdata = 32'hFFFF_FFFF;
    idle(2);
    bus_valid = 1'b0; bus_we = 1'b0;
    rst_n = 1'b1;
    idle(1);
    bus_cycle(1'b0, 32'h000, '0); check("post_rst_data", bus_rdata, 32'h0);
    bus_cycle(1'b0, 32'h004, '0); check("post_rst_dir", bus_rdata, 32'h0);
    check("post_rst_out", gpio_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
